// File: rtl/lane_decoupler_fifo.sv
// Lane decoupler: fans each accepted multi-element beat out to NUM_ELEMENTS
// independent lanes, each buffered by its own DEPTH-entry FIFO, so lanes may
// drift up to DEPTH beats apart before back-pressuring the shared input.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   in_data_i    per-element payload of the input beat
//   in_keep_i    per-element keep flag of the input beat
//   in_last_i    end-of-packet flag, shared by all elements
//   in_valid_i   input beat valid
//   in_ready_o   input beat ready (registered state only, forced low in reset)
//   out_data_o   per-lane payload at the head of each FIFO
//   out_keep_o   per-lane keep at the head of each FIFO
//   out_last_o   per-lane last at the head of each FIFO
//   out_valid_o  per-lane valid (lane FIFO not empty)
//   out_ready_i  per-lane consumer ready
//   idle_o       all lane FIFOs empty
module lane_decoupler_fifo #(
    parameter type         data_t       = logic [7:0],
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned DEPTH        = 4,
    parameter bit          SKIP_EMPTY   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  data_t [NUM_ELEMENTS-1:0] in_data_i,
    input  logic  [NUM_ELEMENTS-1:0] in_keep_i,
    input  logic                     in_last_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output data_t [NUM_ELEMENTS-1:0] out_data_o,
    output logic  [NUM_ELEMENTS-1:0] out_keep_o,
    output logic  [NUM_ELEMENTS-1:0] out_last_o,
    output logic  [NUM_ELEMENTS-1:0] out_valid_o,
    input  logic  [NUM_ELEMENTS-1:0] out_ready_i,
    output logic                     idle_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [NUM_ELEMENTS-1:0] lane_full_q;
    logic [NUM_ELEMENTS-1:0] lane_empty_d;
    logic                    acc;
    logic                    idle_q;

    // Ready looks only at registered full flags; a popping full lane still blocks.
    assign in_ready_o = ~rst & ~(|lane_full_q);
    assign acc        = in_valid_i & in_ready_o;
    assign idle_o     = idle_q;

    for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_lane
        data_t         data_mem_q [DEPTH];
        logic          keep_mem_q [DEPTH];
        logic          last_mem_q [DEPTH];
        logic [AW-1:0] wptr_q, wptr_d;
        logic [AW-1:0] rptr_q, rptr_d;
        logic [CW-1:0] occ_q, occ_d;
        logic          valid_q;
        logic          want;
        logic          push;
        logic          pop;

        // Empty elements are skipped only when they do not carry end-of-packet.
        assign want = SKIP_EMPTY ? (in_keep_i[g] | in_last_i) : 1'b1;
        assign push = acc & want;
        assign pop  = valid_q & out_ready_i[g];

        // Pointer and occupancy next state.
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            occ_d  = occ_q + CW'(push) - CW'(pop);
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
        end

        // Control registers; valid and full are kept registered from occ_d.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_q         <= '0;
                rptr_q         <= '0;
                occ_q          <= '0;
                valid_q        <= 1'b0;
                lane_full_q[g] <= 1'b0;
            end else begin
                wptr_q         <= wptr_d;
                rptr_q         <= rptr_d;
                occ_q          <= occ_d;
                valid_q        <= (occ_d != '0);
                lane_full_q[g] <= (occ_d == CW'(DEPTH));
            end
        end

        // Payload storage is not reset; stale entries are unreachable after reset.
        always_ff @(posedge clk) begin
            if (push) begin
                data_mem_q[wptr_q] <= in_data_i[g];
                keep_mem_q[wptr_q] <= in_keep_i[g];
                last_mem_q[wptr_q] <= in_last_i;
            end
        end

        assign lane_empty_d[g] = (occ_d == '0);
        assign out_valid_o[g]  = valid_q;
        assign out_data_o[g]   = data_mem_q[rptr_q];
        assign out_keep_o[g]   = keep_mem_q[rptr_q];
        assign out_last_o[g]   = last_mem_q[rptr_q];
    end

    // Idle tracks the next-state occupancy of every lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= 1'b1;
        end else begin
            idle_q <= &lane_empty_d;
        end
    end

endmodule

// File: tb/tb_lane_decoupler_fifo.sv
// Bench for lane_decoupler_fifo: instance A (DEPTH=4, no skip) for directed
// scenarios, instance B (DEPTH=2, skip empty) for skip and randomized traffic.
module tb_lane_decoupler_fifo;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic                a_rst;
    logic [N-1:0][7:0]   a_in_data;
    logic [N-1:0]        a_in_keep;
    logic                a_in_last, a_in_valid, a_in_ready;
    logic [N-1:0][7:0]   a_out_data;
    logic [N-1:0]        a_out_keep, a_out_last, a_out_valid, a_out_ready;
    logic                a_idle;

    logic                b_rst;
    logic [N-1:0][7:0]   b_in_data;
    logic [N-1:0]        b_in_keep;
    logic                b_in_last, b_in_valid, b_in_ready;
    logic [N-1:0][7:0]   b_out_data;
    logic [N-1:0]        b_out_keep, b_out_last, b_out_valid, b_out_ready;
    logic                b_idle;

    logic [9:0] got  [N][16];
    int         gotn [N];
    logic [9:0] expw [N][16];
    int         expn [N];

    lane_decoupler_fifo #(.data_t(logic [7:0]), .NUM_ELEMENTS(N), .DEPTH(4), .SKIP_EMPTY(1'b0)) u_a (
        .clk(clk), .rst(a_rst),
        .in_data_i(a_in_data), .in_keep_i(a_in_keep), .in_last_i(a_in_last),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .out_data_o(a_out_data), .out_keep_o(a_out_keep), .out_last_o(a_out_last),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .idle_o(a_idle)
    );

    lane_decoupler_fifo #(.data_t(logic [7:0]), .NUM_ELEMENTS(N), .DEPTH(2), .SKIP_EMPTY(1'b1)) u_b (
        .clk(clk), .rst(b_rst),
        .in_data_i(b_in_data), .in_keep_i(b_in_keep), .in_last_i(b_in_last),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .out_data_o(b_out_data), .out_keep_o(b_out_keep), .out_last_o(b_out_last),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .idle_o(b_idle)
    );

    function automatic logic [7:0] beat(input int base, input int k, input int i);
        return 8'(base + 4 * k + i);
    endfunction

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_a got=%b exp=0", a_in_ready); end
        total++; if (a_out_valid !== 4'h0) begin bad++; $display("FAIL reset_valid_a got=%h exp=0", a_out_valid); end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL reset_idle_a got=%b exp=1", a_idle); end
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_b got=%b exp=0", b_in_ready); end
        total++; if (b_out_valid !== 4'h0) begin bad++; $display("FAIL reset_valid_b got=%h exp=0", b_out_valid); end
        total++; if (b_idle !== 1'b1) begin bad++; $display("FAIL reset_idle_b got=%b exp=1", b_idle); end
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready_a got=%b exp=1", a_in_ready); end
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready_b got=%b exp=1", b_in_ready); end
    endtask

    task automatic test_fanout();
        a_out_ready = 4'hF; a_in_keep = 4'hF;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk); #1;
            if (n > 0) begin
                total++; if (a_out_valid !== 4'hF) begin bad++; $display("FAIL fanout_valid beat=%0d got=%h exp=f", n - 1, a_out_valid); end
                for (int i = 0; i < N; i++) begin
                    total++;
                    if (a_out_data[i] !== beat(0, n - 1, i) || a_out_last[i] !== 1'(n == 8)) begin
                        bad++; $display("FAIL fanout_data lane=%0d got=%h/%b exp=%h/%b", i, a_out_data[i], a_out_last[i], beat(0, n - 1, i), n == 8);
                    end
                end
            end
            if (n < 8) begin
                a_in_valid = 1'b1; a_in_last = 1'(n == 7);
                for (int i = 0; i < N; i++) a_in_data[i] = beat(0, n, i);
                #1;
                total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL fanout_ready beat=%0d got=%b exp=1", n, a_in_ready); end
            end else begin
                a_in_valid = 1'b0; a_in_last = 1'b0;
            end
        end
        @(negedge clk); #1;
        total++; if (a_out_valid !== 4'h0) begin bad++; $display("FAIL fanout_drain_valid got=%h exp=0", a_out_valid); end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL fanout_idle got=%b exp=1", a_idle); end
    endtask

    task automatic test_slow_lane();
        int k;
        a_out_ready = 4'b1011; a_in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (c > 0) begin
                for (int i = 0; i < N; i++) begin
                    logic [7:0] e;
                    e = (i == 2) ? beat(100, 0, i) : beat(100, c - 1, i);
                    total++;
                    if (a_out_valid[i] !== 1'b1 || a_out_data[i] !== e) begin
                        bad++; $display("FAIL slow_fill lane=%0d got=%b/%h exp=1/%h", i, a_out_valid[i], a_out_data[i], e);
                    end
                end
            end
            a_in_valid = 1'b1;
            for (int i = 0; i < N; i++) a_in_data[i] = beat(100, c, i);
            #1;
            total++; if (a_in_ready !== 1'(c < 4)) begin bad++; $display("FAIL slow_ready cycle=%0d got=%b exp=%b", c, a_in_ready, c < 4); end
        end
        @(negedge clk); #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL slow_stall_ready got=%b exp=0", a_in_ready); end
        total++; if (a_out_valid !== 4'b0100) begin bad++; $display("FAIL slow_stall_valid got=%b exp=0100", a_out_valid); end
        for (int i = 0; i < N; i++) gotn[i] = 0;
        k = 4;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (a_out_valid[i] && gotn[i] < 16) begin got[i][gotn[i]] = {a_out_data[i], 2'b00}; gotn[i]++; end
            end
            a_out_ready = 4'hF;
            if (k < 6) begin
                a_in_valid = 1'b1;
                for (int i = 0; i < N; i++) a_in_data[i] = beat(100, k, i);
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (j < 2) begin
                total++; if (a_in_ready !== 1'(j == 1)) begin bad++; $display("FAIL slow_release_ready j=%0d got=%b exp=%b", j, a_in_ready, j == 1); end
            end
            if (a_in_valid && a_in_ready) k++;
        end
        for (int i = 0; i < N; i++) begin
            int first;
            first = (i == 2) ? 0 : 4;
            total++;
            if (gotn[i] != 6 - first) begin
                bad++; $display("FAIL slow_count lane=%0d got=%0d exp=%0d", i, gotn[i], 6 - first);
            end else begin
                for (int m = 0; m < gotn[i]; m++) begin
                    total++;
                    if (got[i][m] !== {beat(100, first + m, i), 2'b00}) begin
                        bad++; $display("FAIL slow_order lane=%0d idx=%0d got=%h exp=%h", i, m, got[i][m][9:2], beat(100, first + m, i));
                    end
                end
            end
        end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL slow_idle got=%b exp=1", a_idle); end
    endtask

    task automatic test_full_pop_push();
        a_out_ready = 4'b1110; a_in_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            a_in_valid = 1'b1;
            for (int i = 0; i < N; i++) a_in_data[i] = beat(160, k, i);
            #1;
            total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL full_fill_ready k=%0d got=%b exp=1", k, a_in_ready); end
        end
        @(negedge clk); #1;
        a_out_ready = 4'hF;
        for (int i = 0; i < N; i++) a_in_data[i] = beat(160, 4, i);
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_cycle_ready got=%b exp=0", a_in_ready); end
        total++; if (a_out_data[0] !== beat(160, 0, 0)) begin bad++; $display("FAIL full_head got=%h exp=%h", a_out_data[0], beat(160, 0, 0)); end
        @(negedge clk); #1;
        a_out_ready = 4'b1110;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop_ready got=%b exp=1", a_in_ready); end
        @(negedge clk); #1;
        a_in_valid = 1'b0;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL full_refill_ready got=%b exp=0", a_in_ready); end
        gotn[0] = 0;
        if (a_out_valid[0]) begin got[0][0] = {a_out_data[0], 2'b00}; gotn[0] = 1; end
        a_out_ready = 4'hF;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); #1;
            if (a_out_valid[0] && gotn[0] < 16) begin got[0][gotn[0]] = {a_out_data[0], 2'b00}; gotn[0]++; end
        end
        total++;
        if (gotn[0] != 4) begin
            bad++; $display("FAIL full_drain_count got=%0d exp=4", gotn[0]);
        end else begin
            for (int m = 0; m < 4; m++) begin
                total++;
                if (got[0][m] !== {beat(160, m + 1, 0), 2'b00}) begin
                    bad++; $display("FAIL full_drain_order idx=%0d got=%h exp=%h", m, got[0][m][9:2], beat(160, m + 1, 0));
                end
            end
        end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL full_idle got=%b exp=1", a_idle); end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 4'h0; a_in_last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            a_in_valid = 1'b1;
            for (int i = 0; i < N; i++) a_in_data[i] = beat(80, k, i);
        end
        @(negedge clk); #1;
        a_rst = 1'b1;
        for (int i = 0; i < N; i++) a_in_data[i] = 8'h77;
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_during got=%b exp=0", a_in_ready); end
        @(negedge clk); #1;
        a_rst = 1'b0;
        total++; if (a_out_valid !== 4'h0) begin bad++; $display("FAIL midrst_valid got=%h exp=0", a_out_valid); end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", a_idle); end
        a_out_ready = 4'hF;
        for (int i = 0; i < N; i++) a_in_data[i] = beat(160, 10, i);
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after got=%b exp=1", a_in_ready); end
        @(negedge clk); #1;
        a_in_valid = 1'b0;
        total++; if (a_out_valid !== 4'hF) begin bad++; $display("FAIL midrst_new_valid got=%h exp=f", a_out_valid); end
        for (int i = 0; i < N; i++) begin
            total++; if (a_out_data[i] !== beat(160, 10, i)) begin bad++; $display("FAIL midrst_new_data lane=%0d got=%h exp=%h", i, a_out_data[i], beat(160, 10, i)); end
        end
        @(negedge clk); #1;
        total++; if (a_out_valid !== 4'h0 || a_idle !== 1'b1) begin bad++; $display("FAIL midrst_drain got=%h/%b exp=0/1", a_out_valid, a_idle); end
    endtask

    task automatic test_skip_empty();
        b_out_ready = 4'h0;
        @(negedge clk); #1;
        b_in_valid = 1'b1; b_in_keep = 4'b0101; b_in_last = 1'b0;
        for (int i = 0; i < N; i++) b_in_data[i] = 8'(8'h10 + i);
        #1;
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL skip_ready_a got=%b exp=1", b_in_ready); end
        @(negedge clk); #1;
        b_in_keep = 4'b0001; b_in_last = 1'b1;
        for (int i = 0; i < N; i++) b_in_data[i] = 8'(8'h20 + i);
        #1;
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL skip_ready_b got=%b exp=1", b_in_ready); end
        @(negedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        total++; if (b_out_valid !== 4'hF) begin bad++; $display("FAIL skip_valid got=%h exp=f", b_out_valid); end
        for (int i = 0; i < N; i++) gotn[i] = 0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            for (int i = 0; i < N; i++) begin
                if (b_out_valid[i] && gotn[i] < 16) begin got[i][gotn[i]] = {b_out_data[i], b_out_keep[i], b_out_last[i]}; gotn[i]++; end
            end
            b_out_ready = 4'hF;
        end
        expw[0][0] = {8'h10, 2'b10}; expw[0][1] = {8'h20, 2'b11}; expn[0] = 2;
        expw[1][0] = {8'h21, 2'b01};                              expn[1] = 1;
        expw[2][0] = {8'h12, 2'b10}; expw[2][1] = {8'h22, 2'b01}; expn[2] = 2;
        expw[3][0] = {8'h23, 2'b01};                              expn[3] = 1;
        for (int i = 0; i < N; i++) begin
            total++;
            if (gotn[i] != expn[i]) begin
                bad++; $display("FAIL skip_count lane=%0d got=%0d exp=%0d", i, gotn[i], expn[i]);
            end else begin
                for (int m = 0; m < expn[i]; m++) begin
                    total++;
                    if (got[i][m] !== expw[i][m]) begin bad++; $display("FAIL skip_entry lane=%0d idx=%0d got=%h exp=%h", i, m, got[i][m], expw[i][m]); end
                end
            end
        end
        total++; if (b_idle !== 1'b1) begin bad++; $display("FAIL skip_idle got=%b exp=1", b_idle); end
    endtask

    logic [9:0] mq [N][1024];

    task automatic test_wrap_random();
        int  mh [N];
        int  mt [N];
        int  acc_n;
        int  cyc;
        bit  vld;
        bit  mrdy;
        bit  busy;
        for (int i = 0; i < N; i++) begin mh[i] = 0; mt[i] = 0; end
        acc_n = 0; cyc = 0; busy = 1'b1;
        while (busy && cyc < 20000) begin
            @(negedge clk); #1;
            cyc++;
            vld = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
            b_in_valid = vld;
            b_in_keep  = 4'($urandom);
            b_in_last  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) b_in_data[i] = 8'($urandom);
            b_out_ready = 4'($urandom);
            #1;
            mrdy = 1'b1;
            for (int i = 0; i < N; i++) if (mt[i] - mh[i] >= 2) mrdy = 1'b0;
            total++; if (b_in_ready !== mrdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, b_in_ready, mrdy); end
            for (int i = 0; i < N; i++) begin
                total++;
                if (b_out_valid[i] !== 1'(mt[i] != mh[i])) begin
                    bad++; $display("FAIL rand_valid cyc=%0d lane=%0d got=%b exp=%b", cyc, i, b_out_valid[i], mt[i] != mh[i]);
                end
                if (mt[i] != mh[i]) begin
                    total++;
                    if ({b_out_data[i], b_out_keep[i], b_out_last[i]} !== mq[i][mh[i]]) begin
                        bad++; $display("FAIL rand_data cyc=%0d lane=%0d got=%h exp=%h", cyc, i, {b_out_data[i], b_out_keep[i], b_out_last[i]}, mq[i][mh[i]]);
                    end
                    if (b_out_ready[i]) mh[i]++;
                end
            end
            if (vld && mrdy) begin
                acc_n++;
                for (int i = 0; i < N; i++) begin
                    if ((b_in_keep[i] || b_in_last) && mt[i] < 1024) begin
                        mq[i][mt[i]] = {b_in_data[i], b_in_keep[i], b_in_last};
                        mt[i]++;
                    end
                end
            end
            busy = (acc_n < 1000);
            for (int i = 0; i < N; i++) if (mt[i] != mh[i]) busy = 1'b1;
        end
        b_in_valid = 1'b0;
        total++; if (busy) begin bad++; $display("FAIL rand_timeout accepted=%0d exp=1000", acc_n); end
        @(negedge clk); #1;
        total++; if (b_idle !== 1'b1) begin bad++; $display("FAIL rand_idle got=%b exp=1", b_idle); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_in_data = '0; a_in_keep = 4'hF; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 4'hF;
        b_rst = 1'b1; b_in_data = '0; b_in_keep = 4'hF; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 4'hF;
        test_reset();
        test_fanout();
        test_slow_lane();
        test_full_pop_push();
        test_reset_mid();
        test_skip_empty();
        test_wrap_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_decoupler_fifo.md
# lane_decoupler_fifo

Splits each multi-element beat of an `ndata_i` stream into `NUM_ELEMENTS` independent `data_i` streams, with a `DEPTH`-entry FIFO per lane. Lanes can drift up to `DEPTH` beats apart, so one slow consumer does not stall the others until its FIFO fills. An optional mode drops empty (keep = 0) elements so lanes only receive meaningful beats. It sits in the crossbar between wide ingress streams and per-element processing pipelines.

## Interface
- `data_t`, no default: element payload type.
- `NUM_ELEMENTS`, no default: number of lanes, ≥1.
- `DEPTH`, 4: per-lane FIFO entries; power of two, ≥2.
- `SKIP_EMPTY`, 0: when 1, an element with keep = 0 is not pushed to its lane unless the beat has last = 1.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  `ndata_i.s`  `#(data_t, NUM_ELEMENTS)`  input beat, carrying `data[i]`, `keep[i]`, `last`, `valid` and `ready`.
- `out[NUM_ELEMENTS]`  `data_i.m`  `#(data_t)`  per-lane output, carrying `data`, `keep`, `last`, `valid` and `ready`.
- `idle`  out  1  high when all lane FIFOs are empty.

## Operation
- **Per-lane state:**
  - storage of `DEPTH` × {data, keep, last};
  - write and read pointers, `$clog2(DEPTH)` bits each, wrapping modulo `DEPTH`;
  - an occupancy counter, `$clog2(DEPTH)+1` bits, ranging 0..`DEPTH`.
- **Lane full:** occupancy == `DEPTH`.
- **Input ready:** `in.ready` = no lane full, and not `rst`.
  - It depends only on registered state.
  - There is no combinational path from `in.valid` or `out[i].ready` to `in.ready`.
- **Accept:** `acc = in.valid & in.ready`.
- **Push:** lane i pushes when `acc & want[i]`.
  - `want[i] = 1` when `SKIP_EMPTY` = 0.
  - `want[i] = |in.keep[i] | in.last` when `SKIP_EMPTY` = 1.
- **Pushed entry:** {`in.data[i]`, `in.keep[i]`, `in.last`}.
- **Last propagation:** `last` always propagates to every lane, so each lane sees end-of-packet even with `SKIP_EMPTY`.
- **Output:**
  - `out[i].valid` = occupancy[i] ≠ 0.
  - `out[i].data`/`.keep`/`.last` = entry at the read pointer.
  - Pop when `out[i].valid & out[i].ready`.
- **Occupancy update:** occupancy += push − pop; a simultaneous push and pop leaves it unchanged.
- **Ordering:** each lane's output order equals input order for the beats pushed to it.
- **Payload integrity:** data/keep are never altered.
- **`idle`** = all occupancies zero.
- **Reset:** while `rst` is high at a clock edge:
  - pointers and occupancies go to 0;
  - all `out[i].valid` = 0 and `idle` = 1 from the next cycle;
  - `in.ready` is forced to 0 during the reset cycle;
  - stored payload is discarded; a mid-packet reset drops partial packets with no flush.
- **Stability:** once `out[i].valid` is asserted, `out[i].valid` and the payload stay stable until popped (AXI-stream rule).

## Timing
- **Latency:** input accept at edge t → entry visible on an empty lane's `out` after edge t (one cycle). There is no bypass path.
- **Throughput:** one input beat per cycle while no lane is full and all consumers pop every cycle.
- **Full lane:**
  - when any lane is full, `in.ready` = 0 that cycle, even if that lane pops in the same cycle;
  - ready returns the cycle after the pop. This is the cost of a registered ready.
- **Empty lane:** a pop never occurs when empty because valid = 0; a push into an empty lane makes valid 1 next cycle.
- **Pointer wrap:** pointers wrap from `DEPTH`−1 to 0 with no bubble.
- **Skipped elements:** with `SKIP_EMPTY` = 1 and keep = 0, the occupancy of that lane is unchanged; the beat is still accepted by the others.
- **Reset values:**
  - `out[i].valid` = 0;
  - `in.ready` = 0 while `rst` = 1, and 1 in the first cycle after `rst` falls;
  - `idle` = 1.

## Test plan
- **Basic fan-out:** `NUM_ELEMENTS`=4, `DEPTH`=4; push 8 beats with data {4n+i}, all outputs ready → lane i emits i, 4+i, …, 28+i, each 1 cycle after accept; `in.ready` stays 1; `idle`=1 after drain.
- **Slow lane:** hold lane 2 ready=0 and push 6 beats.
  - The first 4 beats are accepted; `in.ready` goes 0 once lane 2 occupancy = 4.
  - The other lanes emit beats 0..3.
  - Release lane 2 → it emits beats 0..3 in order; `in.ready` returns the cycle after its first pop; beats 4 and 5 follow on all lanes.
- **Skip empty:** `SKIP_EMPTY`=1; beat A keep=4'b0101 last=0, beat B keep=4'b0001 last=1.
  - Lanes 0 and 2 get A.
  - All 4 lanes get B with last=1; lanes 1–3 get keep=0.
- **Wrap-around with random stall:** `DEPTH`=2, 1000 beats, random per-lane ready (50%) → every lane's sequence matches the scoreboard exactly, with no loss or duplication, and occupancy never exceeds 2.
- **Reset mid-operation:** fill lanes partially, assert `rst` for 1 cycle → next cycle all `out[i].valid`=0, `idle`=1; `in.ready` is 0 during reset and 1 after; new beats emit correctly with no stale data.
- **Pop and push at a full lane:** lane full and popping while input valid → no accept that cycle (`in.ready`=0); accept on the following cycle; occupancy goes `DEPTH` → `DEPTH`−1 → `DEPTH`.
